core_opmux_fwd: RTL and testbench
=================================

CORE_OPMUX_FWD -- requirements
Module: core_opmux_fwd

Interface
REQ-001 SHALL have parameter DW, 32, operand/data width in bits.
REQ-002 SHALL have parameter AW, 5, register address width in bits.
REQ-003 SHALL have parameter CW, 16, hazard-counter width in bits.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous reset, active-high.
REQ-006 id_valid  input  1  ID offers an operand set; id_ready  output  1  block accepts it this cycle.
REQ-007 ra, rb  input  DW  register-file read data; ra_addr, rb_addr  input  AW  source addresses; ra_use, rb_use  input  1  source actually read.
REQ-008 id_pc, imm  input  DW  PC and immediate; sel_a  input  2  A select; sel_b  input  2  B select.
REQ-009 ex_wr_en  input  1; ex_wr_addr  input  AW; ex_wr_data  input  DW; ex_is_load  input  1  EX result not yet available.
REQ-010 wb_wr_en  input  1; wb_wr_addr  input  AW; wb_wr_data  input  DW  writeback result.
REQ-011 ex_ready  input  1  EX consumes a/b this cycle; flush  input  1  discard held and offered operands.
REQ-012 a, b  output  DW  registered operands; op_valid  output  1  a/b valid; hazard_cnt  output  CW  saturating stall-cycle count.

Function
REQ-013 Source value: EX forward if ex_wr_en and ex_wr_addr==src addr, else WB forward if wb_wr_en and wb_wr_addr==src addr, else regfile; address 0 never forwarded (regfile value used).
REQ-014 sel_a: 0 forwarded RA, 1 id_pc, 2 wb_wr_data, 3 zero.
REQ-015 sel_b: 0 forwarded RB, 1 id_pc, 2 imm, 3 wb_wr_data.
REQ-016 Hazard = used source (use=1, addr!=0) matches ex_wr_addr with ex_wr_en and ex_is_load.
REQ-017 id_ready = (~op_valid | ex_ready) & ~hazard & ~flush, combinational.
REQ-018 Accept = id_valid & id_ready; on accept, a/b/op_valid=1 load next edge (latency 1 cycle).
REQ-019 States EMPTY (op_valid=0) / FULL (op_valid=1): EMPTY->FULL on accept; FULL->EMPTY on ex_ready without accept; FULL->FULL on ex_ready with accept (back-to-back, no bubble) or on ~ex_ready (a/b held stable).
REQ-020 flush: op_valid=0 next edge from either state, overriding accept and hold; a/b value then don't-care.
REQ-021 hazard_cnt increments each cycle id_valid & hazard & ~flush; saturates at 2^CW-1, no wrap.
REQ-022 Both sources hazarding same cycle counts once.
REQ-023 All arithmetic/compare on full AW/DW widths; no truncation.

Reset
REQ-024 rst asserted: a=0, b=0, op_valid=0, hazard_cnt=0 immediately, independent of clk.
REQ-025 rst mid-transfer: held operand discarded; first accept allowed on first edge after rst deasserts.

Configuration
REQ-026 Macro CORE_OPMUX_FWD_EN: defined -> REQ-013/REQ-016 as stated.
REQ-027 Not defined -> no forwarding (regfile value always used); hazard = used nonzero source matching ex_wr_addr (ex_wr_en) or wb_wr_addr (wb_wr_en), regardless of ex_is_load.

Verification
REQ-028 Reset with rst=1 mid-cycle -> a=b=0, op_valid=0, hazard_cnt=0 before next edge.
REQ-029 FWD_EN; ra_addr=3 ra_use=1 sel_a=0, ex_wr_en=1 ex_wr_addr=3 ex_wr_data=0xAAAA0001, wb_wr_en=1 wb_wr_addr=3 -> a=0xAAAA0001 after 1 cycle; ra_addr=0 same inputs -> a=ra.
REQ-030 FWD_EN; ex_is_load=1 matching rb_addr=5 rb_use=1 for 3 cycles -> id_ready=0 3 cycles, hazard_cnt=3, accept on 4th cycle.
REQ-031 op_valid=1, ex_ready=0 for 4 cycles with new id_valid -> a/b unchanged, id_ready=0; ex_ready=1 -> next operand loaded, no bubble.
REQ-032 flush=1 with id_valid=1 while FULL -> op_valid=0 next cycle, offered set dropped.
REQ-033 FWD_EN undefined; wb_wr_en=1 wb_wr_addr=7, ra_addr=7 ra_use=1 -> id_ready=0, hazard_cnt increments; CW=2 with 5 stalls -> hazard_cnt=3.

Source files
------------

// File: rtl/core_opmux_fwd.sv
// Operand mux with EX/WB forwarding, load-use hazard stall and a one-entry output stage.
// Build macro CORE_OPMUX_FWD_EN enables forwarding; undefined, any pending write to a used source stalls.
module core_opmux_fwd #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    output logic          id_ready,
    input  logic [DW-1:0] ra,
    input  logic [DW-1:0] rb,
    input  logic [AW-1:0] ra_addr,
    input  logic [AW-1:0] rb_addr,
    input  logic          ra_use,
    input  logic          rb_use,
    input  logic [DW-1:0] id_pc,
    input  logic [DW-1:0] imm,
    input  logic [1:0]    sel_a,
    input  logic [1:0]    sel_b,
    input  logic          ex_wr_en,
    input  logic [AW-1:0] ex_wr_addr,
    input  logic [DW-1:0] ex_wr_data,
    input  logic          ex_is_load,
    input  logic          wb_wr_en,
    input  logic [AW-1:0] wb_wr_addr,
    input  logic [DW-1:0] wb_wr_data,
    input  logic          ex_ready,
    input  logic          flush,
    output logic [DW-1:0] a,
    output logic [DW-1:0] b,
    output logic          op_valid,
    output logic [CW-1:0] hazard_cnt
);

    // Handshake: an operand set moves from ID on a cycle with id_valid & id_ready;
    // a/b move to EX on a cycle with op_valid & ex_ready. flush overrides both.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t        state;
    logic [DW-1:0] ra_val;
    logic [DW-1:0] rb_val;
    logic [DW-1:0] a_next;
    logic [DW-1:0] b_next;
    logic          haz_a;
    logic          haz_b;
    logic          hazard;
    logic          accept;

`ifdef CORE_OPMUX_FWD_EN
    // EX has priority over WB; register 0 is hardwired and never forwarded.
    always_comb begin
        ra_val = ra;
        if (ra_addr != '0) begin
            if (ex_wr_en && (ex_wr_addr == ra_addr)) begin
                ra_val = ex_wr_data;
            end else if (wb_wr_en && (wb_wr_addr == ra_addr)) begin
                ra_val = wb_wr_data;
            end
        end
    end

    always_comb begin
        rb_val = rb;
        if (rb_addr != '0) begin
            if (ex_wr_en && (ex_wr_addr == rb_addr)) begin
                rb_val = ex_wr_data;
            end else if (wb_wr_en && (wb_wr_addr == rb_addr)) begin
                rb_val = wb_wr_data;
            end
        end
    end

    // Only a load in EX cannot be forwarded in time.
    assign haz_a = ra_use && (ra_addr != '0) && ex_wr_en && ex_is_load && (ex_wr_addr == ra_addr);
    assign haz_b = rb_use && (rb_addr != '0) && ex_wr_en && ex_is_load && (ex_wr_addr == rb_addr);
`else
    logic unused_ok;

    assign unused_ok = ^{ex_wr_data, ex_is_load};
    assign ra_val    = ra;
    assign rb_val    = rb;

    // Without forwarding, every in-flight write to a used source must retire first.
    assign haz_a = ra_use && (ra_addr != '0) &&
                   ((ex_wr_en && (ex_wr_addr == ra_addr)) || (wb_wr_en && (wb_wr_addr == ra_addr)));
    assign haz_b = rb_use && (rb_addr != '0) &&
                   ((ex_wr_en && (ex_wr_addr == rb_addr)) || (wb_wr_en && (wb_wr_addr == rb_addr)));
`endif

    assign hazard = haz_a || haz_b;

    always_comb begin
        a_next = '0;
        case (sel_a)
            2'd0:    a_next = ra_val;
            2'd1:    a_next = id_pc;
            2'd2:    a_next = wb_wr_data;
            default: a_next = '0;
        endcase
    end

    always_comb begin
        b_next = '0;
        case (sel_b)
            2'd0:    b_next = rb_val;
            2'd1:    b_next = id_pc;
            2'd2:    b_next = imm;
            default: b_next = wb_wr_data;
        endcase
    end

    assign id_ready = ((state == EMPTY) || ex_ready) && !hazard && !flush;
    assign accept   = id_valid && id_ready;
    assign op_valid = (state == FULL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
            a     <= '0;
            b     <= '0;
        end else if (flush) begin
            state <= EMPTY;
        end else if (accept) begin
            state <= FULL;
            a     <= a_next;
            b     <= b_next;
        end else if (ex_ready) begin
            state <= EMPTY;
        end
    end

    // Counts stalled offers once per cycle, whichever sources collide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hazard_cnt <= '0;
        end else if (id_valid && hazard && !flush && (hazard_cnt != '1)) begin
            hazard_cnt <= hazard_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_core_opmux_fwd.sv
// Scoreboard bench for core_opmux_fwd; expectations follow CORE_OPMUX_FWD_EN when defined.
module tb_core_opmux_fwd;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 2;

    logic          clk;
    logic          rst;
    logic          id_valid;
    logic          id_ready;
    logic [DW-1:0] ra, rb, id_pc, imm, ex_wr_data, wb_wr_data;
    logic [AW-1:0] ra_addr, rb_addr, ex_wr_addr, wb_wr_addr;
    logic          ra_use, rb_use, ex_wr_en, ex_is_load, wb_wr_en, ex_ready, flush;
    logic [1:0]    sel_a, sel_b;
    logic [DW-1:0] a, b;
    logic          op_valid;
    logic [CW-1:0] hazard_cnt;

    logic [2*DW-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    core_opmux_fwd #(.DW(DW), .AW(AW), .CW(CW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
        .ra(ra), .rb(rb), .ra_addr(ra_addr), .rb_addr(rb_addr),
        .ra_use(ra_use), .rb_use(rb_use), .id_pc(id_pc), .imm(imm),
        .sel_a(sel_a), .sel_b(sel_b),
        .ex_wr_en(ex_wr_en), .ex_wr_addr(ex_wr_addr), .ex_wr_data(ex_wr_data), .ex_is_load(ex_is_load),
        .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr), .wb_wr_data(wb_wr_data),
        .ex_ready(ex_ready), .flush(flush),
        .a(a), .b(b), .op_valid(op_valid), .hazard_cnt(hazard_cnt)
    );

    // Clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_valid = 0; ra = '0; rb = '0; ra_addr = '0; rb_addr = '0; ra_use = 0; rb_use = 0;
        id_pc = '0; imm = '0; sel_a = 2'd0; sel_b = 2'd0;
        ex_wr_en = 0; ex_wr_addr = '0; ex_wr_data = '0; ex_is_load = 0;
        wb_wr_en = 0; wb_wr_addr = '0; wb_wr_data = '0; ex_ready = 0; flush = 0;
    endtask

    // Offer the current operand set; it must be accepted at the next edge.
    task automatic offer(input logic [DW-1:0] ea, input logic [DW-1:0] eb, input bit track);
        id_valid = 1;
        #1;
        check("id_ready_offer", 64'(id_ready), 64'd1);
        if (track) exp_q.push_back({ea, eb});
        step();
    endtask

    task automatic stall_cycle(input string name);
        id_valid = 1;
        #1;
        check(name, 64'(id_ready), 64'd0);
        step();
    endtask

    task automatic do_reset();
        rst = 1;
        step();
        rst = 0;
        exp_q.delete();
    endtask

    // Scoreboard monitor: pops whenever EX takes the operand pair.
    always @(negedge clk) begin
        logic [2*DW-1:0] e;
        if (!rst && op_valid && ex_ready && !flush) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output actual=%h_%h required=none", a, b);
            end else begin
                e = exp_q.pop_front();
                if ({a, b} !== e) begin
                    n_fail++;
                    $display("FAIL operand_pair actual=%h_%h required=%h_%h", a, b, e[2*DW-1:DW], e[DW-1:0]);
                end
            end
        end
    end

    initial begin
        clear_inputs();
        rst = 1;
        step();
        check("reset_a", 64'(a), 64'd0);
        check("reset_op_valid", 64'(op_valid), 64'd0);
        check("reset_hazard_cnt", 64'(hazard_cnt), 64'd0);
        rst = 0;

        // Mux selections, back-to-back with no bubble
        ex_ready = 1;
        ra = 32'h1111_1111; ra_addr = 5'd1; ra_use = 1;
        rb = 32'h2222_2222; rb_addr = 5'd2; rb_use = 1;
        id_pc = 32'h0000_0400; imm = 32'h1234_5678; wb_wr_data = 32'h9999_0009;
        sel_a = 2'd0; sel_b = 2'd0; offer(32'h1111_1111, 32'h2222_2222, 1);
        sel_a = 2'd1; sel_b = 2'd1; offer(32'h0000_0400, 32'h0000_0400, 1);
        check("op_valid_stream", 64'(op_valid), 64'd1);
        sel_a = 2'd2; sel_b = 2'd2; offer(32'h9999_0009, 32'h1234_5678, 1);
        sel_a = 2'd3; sel_b = 2'd3; offer(32'h0000_0000, 32'h9999_0009, 1);
        id_valid = 0;
        step();
        check("op_valid_drain", 64'(op_valid), 64'd0);

        // Forwarding / no-forwarding
        sel_a = 2'd0; sel_b = 2'd0;
        ra = 32'h0000_3333; ra_addr = 5'd3; ra_use = 1;
        rb = 32'h0000_4444; rb_addr = 5'd4; rb_use = 1;
        ex_wr_en = 1; ex_wr_addr = 5'd3; ex_wr_data = 32'hAAAA_0001; ex_is_load = 0;
        wb_wr_en = 1; wb_wr_addr = 5'd3; wb_wr_data = 32'hBBBB_0002;
`ifdef CORE_OPMUX_FWD_EN
        offer(32'hAAAA_0001, 32'h0000_4444, 1);
        ra_addr = 5'd0; offer(32'h0000_3333, 32'h0000_4444, 1);
        ex_wr_addr = 5'd0; wb_wr_addr = 5'd0; offer(32'h0000_3333, 32'h0000_4444, 1);
        ra_addr = 5'd3; ex_wr_en = 0; wb_wr_addr = 5'd4;
        offer(32'h0000_3333, 32'hBBBB_0002, 1);
`else
        stall_cycle("id_ready_ex_match");
        ra_use = 0; offer(32'h0000_3333, 32'h0000_4444, 1);
        ra_use = 1; ex_wr_en = 0; wb_wr_addr = 5'd7; ra_addr = 5'd7;
        stall_cycle("id_ready_wb_match");
        ra_addr = 5'd0; wb_wr_addr = 5'd0; offer(32'h0000_3333, 32'h0000_4444, 1);
`endif
        id_valid = 0;
        step();

        // Hazard counting and saturation
        clear_inputs();
        do_reset();
        check("hazard_cnt_cleared", 64'(hazard_cnt), 64'd0);
        ex_ready = 1;
        ra = 32'h5555_0005; rb = 32'h6666_0006; ex_wr_data = 32'hEEEE_000E; wb_wr_data = 32'hCCCC_000C;
        ra_addr = 5'd5; rb_addr = 5'd5; ra_use = 1; rb_use = 1;
`ifdef CORE_OPMUX_FWD_EN
        ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 5'd5;
`else
        wb_wr_en = 1; wb_wr_addr = 5'd5;
`endif
        stall_cycle("id_ready_stall1");
        check("hazard_cnt_double_once", 64'(hazard_cnt), 64'd1);
        id_valid = 0; step();
        check("hazard_cnt_no_valid", 64'(hazard_cnt), 64'd1);
        flush = 1; id_valid = 1; step();
        check("hazard_cnt_flush", 64'(hazard_cnt), 64'd1);
        flush = 0; ra_use = 0;
        stall_cycle("id_ready_stall2");
        stall_cycle("id_ready_stall3");
        check("hazard_cnt_three", 64'(hazard_cnt), 64'd3);
        stall_cycle("id_ready_stall4");
        stall_cycle("id_ready_stall5");
        check("hazard_cnt_saturate", 64'(hazard_cnt), 64'd3);
        rb_use = 0;
`ifdef CORE_OPMUX_FWD_EN
        offer(32'hEEEE_000E, 32'hEEEE_000E, 1);
`else
        offer(32'h5555_0005, 32'h6666_0006, 1);
`endif
        ex_wr_en = 0; wb_wr_en = 0; ra_use = 1; rb_use = 1;
        offer(32'h5555_0005, 32'h6666_0006, 1);
        id_valid = 0;
        step();

        // Hold while EX stalls, then back-to-back refill
        ex_ready = 0;
        sel_a = 2'd1; sel_b = 2'd2; id_pc = 32'h0000_1000; imm = 32'h0000_0ABC;
        offer(32'h0000_1000, 32'h0000_0ABC, 1);
        id_pc = 32'h0000_2000; imm = 32'h0000_0DEF;
        for (int i = 0; i < 4; i++) begin
            stall_cycle("id_ready_hold");
            check("hold_a", 64'(a), 64'h1000);
            check("hold_b", 64'(b), 64'h0ABC);
        end
        ex_ready = 1;
        offer(32'h0000_2000, 32'h0000_0DEF, 1);
        check("no_bubble_valid", 64'(op_valid), 64'd1);
        id_valid = 0;
        step();
        check("full_to_empty", 64'(op_valid), 64'd0);

        // Flush from FULL and from EMPTY
        ex_ready = 0; sel_a = 2'd1; sel_b = 2'd1; id_pc = 32'h0000_3000;
        offer('0, '0, 0);
        check("flush_pre_full", 64'(op_valid), 64'd1);
        id_pc = 32'h0000_4000; flush = 1;
        stall_cycle("id_ready_flush");
        check("flush_full", 64'(op_valid), 64'd0);
        flush = 0; id_valid = 0; ex_ready = 1;
        step();
        check("flush_dropped", 64'(op_valid), 64'd0);
        flush = 1; id_valid = 1;
        step();
        check("flush_empty", 64'(op_valid), 64'd0);
        flush = 0; id_valid = 0;

        // Asynchronous reset mid-cycle while holding an operand
        ex_ready = 0; id_pc = 32'h0000_5000;
        offer('0, '0, 0);
        id_valid = 0;
        #2;
        rst = 1;
        #1;
        check("async_rst_a", 64'(a), 64'd0);
        check("async_rst_b", 64'(b), 64'd0);
        check("async_rst_op_valid", 64'(op_valid), 64'd0);
        check("async_rst_hazard_cnt", 64'(hazard_cnt), 64'd0);
        step();
        rst = 0;
        exp_q.delete();
        ex_ready = 1; sel_a = 2'd0; sel_b = 2'd2; ra = 32'h7777_0007; ra_addr = 5'd9; imm = 32'h0000_0042;
        offer(32'h7777_0007, 32'h0000_0042, 1);
        id_valid = 0;
        step();
        step();
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
